// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the execute stage and muldiv_unit.
interface muldiv_unit_if #(
    parameter int DW = 32
);
    logic          start_i;
    logic [2:0]    funct3_i;
    logic [DW-1:0] operand_1_i;
    logic [DW-1:0] operand_2_i;
    logic          flush_i;
    logic          busy_o;
    logic          done_o;
    logic [DW-1:0] result_o;

    modport master (
        output start_i, funct3_i, operand_1_i, operand_2_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, operand_1_i, operand_2_i, flush_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide on one shared shift/add datapath.
// Define MULDIV_FAST_MUL_EN to make multiplies single-cycle with a combinational multiplier.
module muldiv_unit #(
    parameter int DW = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(DW);
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_next;

    logic [2:0]    funct3;
    logic [DW-1:0] addend;
    logic [2*DW:0] work;
    logic          neg_result;
    logic [CW-1:0] count;
    logic [DW-1:0] result;

    logic          in_div, sgn_1_en, sgn_2_en, sign_1, sign_2, in_sign;
    logic [DW-1:0] mag_1_in, mag_2_in;
    logic          div_by_zero, div_ovf, special;
    logic [DW-1:0] special_result;
    logic          fast_take, immediate;
    logic [DW-1:0] fast_result, immediate_result;
    logic          last_step;

    logic [DW:0]     mul_sum, div_shift, div_trial;
    logic [2*DW:0]   work_step;
    logic [2*DW-1:0] prod_s;
    logic [DW-1:0]   quo_s, rem_s, final_result;

    // Request decode: operand magnitudes, result sign and early-finish cases.
    always_comb begin
        in_div   = bus.funct3_i[2];
        sgn_1_en = in_div ? ~bus.funct3_i[0] : (bus.funct3_i[1:0] != 2'b11);
        sgn_2_en = in_div ? ~bus.funct3_i[0] : ~bus.funct3_i[1];
        sign_1   = sgn_1_en & bus.operand_1_i[DW-1];
        sign_2   = sgn_2_en & bus.operand_2_i[DW-1];
        mag_1_in = sign_1 ? -bus.operand_1_i : bus.operand_1_i;
        mag_2_in = sign_2 ? -bus.operand_2_i : bus.operand_2_i;
        in_sign  = (in_div && bus.funct3_i[1]) ? sign_1 : (sign_1 ^ sign_2);

        div_by_zero = in_div && (bus.operand_2_i == '0);
        div_ovf     = in_div && !bus.funct3_i[0] && (bus.operand_1_i == MIN_NEG)
                      && (bus.operand_2_i == '1);
        special     = div_by_zero || div_ovf;
        if (div_by_zero)
            special_result = bus.funct3_i[1] ? bus.operand_1_i : '1;
        else
            special_result = bus.funct3_i[1] ? '0 : bus.operand_1_i;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*DW-1:0] fast_a, fast_b, fast_prod;

    always_comb begin
        fast_a      = {{DW{sign_1}}, bus.operand_1_i};
        fast_b      = {{DW{sgn_2_en & bus.operand_2_i[DW-1]}}, bus.operand_2_i};
        fast_prod   = fast_a * fast_b;
        fast_take   = !in_div;
        fast_result = (bus.funct3_i[1:0] == 2'b00) ? fast_prod[DW-1:0] : fast_prod[2*DW-1:DW];
    end
`else
    always_comb begin
        fast_take   = 1'b0;
        fast_result = '0;
    end
`endif

    always_comb begin
        immediate        = special || fast_take;
        immediate_result = special ? special_result : fast_result;
    end

    // One iteration: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, work[2*DW-1:DW]} + (work[0] ? {1'b0, addend} : '0);
        div_shift = {work[2*DW-1:DW], work[DW-1]};
        div_trial = div_shift - {1'b0, addend};
        if (funct3[2])
            work_step = div_trial[DW] ? {div_shift, work[DW-2:0], 1'b0}
                                      : {div_trial, work[DW-2:0], 1'b1};
        else
            work_step = {1'b0, mul_sum, work[DW-1:1]};

        prod_s = neg_result ? -work_step[2*DW-1:0] : work_step[2*DW-1:0];
        quo_s  = neg_result ? -work_step[DW-1:0] : work_step[DW-1:0];
        rem_s  = neg_result ? -work_step[2*DW-1:DW] : work_step[2*DW-1:DW];
        if (funct3[2])
            final_result = funct3[1] ? rem_s : quo_s;
        else
            final_result = (funct3[1:0] == 2'b00) ? prod_s[DW-1:0] : prod_s[2*DW-1:DW];
        last_step = (count == CW'(DW - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Flush takes priority over the final iteration so an aborted op never reports.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start_i) state_next = immediate ? DONE : CALC;
            CALC: begin
                if (bus.flush_i)
                    state_next = IDLE;
                else if (last_step)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        bus.busy_o   = (state == CALC);
        bus.done_o   = (state == DONE);
        bus.result_o = result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct3     <= '0;
            addend     <= '0;
            work       <= '0;
            neg_result <= 1'b0;
            count      <= '0;
            result     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        funct3     <= bus.funct3_i;
                        addend     <= in_div ? mag_2_in : mag_1_in;
                        work       <= {{(DW+1){1'b0}}, in_div ? mag_1_in : mag_2_in};
                        neg_result <= in_sign;
                        count      <= '0;
                        if (immediate)
                            result <= immediate_result;
                    end
                end
                CALC: begin
                    if (!bus.flush_i) begin
                        work  <= work_step;
                        count <= count + 1'b1;
                        if (last_step)
                            result <= final_result;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
